// File: rtl/data_mem_unit_pkg.sv
// data_mem_unit_pkg: address-map offsets, funct3 encodings and load-lane extraction
// shared by the data memory stage.
package data_mem_unit_pkg;
   localparam logic [31:0] TX_OFF     = 32'h0;
   localparam logic [31:0] STATUS_OFF = 32'h4;
   localparam logic [31:0] CYCLE_OFF  = 32'h8;
   typedef enum logic [2:0] {
      F3_B  = 3'b000,
      F3_H  = 3'b001,
      F3_W  = 3'b010,
      F3_BU = 3'b100,
      F3_HU = 3'b101
   } funct3_t;
   // Picks the addressed lane out of a RAM word and extends it; unknown sizes read 0.
   function automatic logic [31:0] load_lane(input logic [31:0] w, input logic [1:0] a, input logic [2:0] f3);
      logic [7:0] b;
      logic [15:0] h;
      b = w[{a, 3'b000} +: 8];
      h = a[1] ? w[31:16] : w[15:0];
      return f3 == F3_B  ? {{24{b[7]}}, b} :
             f3 == F3_BU ? {24'b0, b} :
             f3 == F3_H  ? {{16{h[15]}}, h} :
             f3 == F3_HU ? {16'b0, h} :
             f3 == F3_W  ? w : '0;
   endfunction
endpackage

// File: rtl/data_mem_unit_if.sv
// data_mem_unit_if: load/store bus from the datapath plus the debug TX valid/ready stream.
interface data_mem_unit_if;
   logic [31:0] ALUResult;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic [2:0]  funct3;
   logic        MemWrite;
   logic        misaligned;
   logic        dbg_valid;
   logic        dbg_ready;
   logic [7:0]  dbg_data;
   modport master (
      output ALUResult, WriteData, MemWrite, funct3, dbg_ready,
      input  ReadData, misaligned, dbg_valid, dbg_data
   );
   modport slave (
      input  ALUResult, WriteData, MemWrite, funct3, dbg_ready,
      output ReadData, misaligned, dbg_valid, dbg_data
   );
endinterface

// File: rtl/data_mem_unit_fifo.sv
// sync_fifo: registered-head FIFO; a push while full is accepted only when a pop frees a slot.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] count;
   logic do_push, do_pop;
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign full    = count == (AW+1)'(DEPTH);
   assign empty   = count == '0;
   // Gate the head so a freshly reset FIFO shows 0 regardless of stale storage.
   assign dout    = empty ? '0 : mem[rd_ptr];
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= din;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
endmodule

// File: rtl/data_mem_unit.sv
// data_mem_unit: RISC-V data memory stage with byte/half/word lanes, misalignment detection,
// a memory-mapped cycle counter and a memory-mapped debug TX FIFO.
module data_mem_unit
   import data_mem_unit_pkg::*;
#(
   parameter int          DEPTH_WORDS = 256,
   parameter logic [31:0] MMIO_BASE   = 32'h0000_1000,
   parameter int          FIFO_DEPTH  = 4
) (
   input logic            clk,
   input logic            reset,
   data_mem_unit_if.slave bus
);
   localparam int AW = $clog2(DEPTH_WORDS);
   logic [31:0] ram [DEPTH_WORDS];
   logic [31:0] addr, word, wdata, cycle, mmio_rd;
   logic [2:0] f3;
   logic [3:0] be;
   logic [AW-1:0] widx;
   logic known, is_half, is_word, mis, in_ram, at_tx, at_status, at_cycle;
   logic store, push, pop, full, empty, overflow;
   assign addr      = bus.ALUResult;
   assign f3        = bus.funct3;
   assign is_half   = f3 == F3_H || f3 == F3_HU;
   assign is_word   = f3 == F3_W;
   assign known     = is_half || is_word || f3 == F3_B || f3 == F3_BU;
   assign mis       = (is_half && addr[0]) || (is_word && addr[1:0] != 2'b00);
   assign in_ram    = addr < 32'(DEPTH_WORDS * 4);
   assign at_tx     = addr == MMIO_BASE + TX_OFF;
   assign at_status = addr == MMIO_BASE + STATUS_OFF;
   assign at_cycle  = addr == MMIO_BASE + CYCLE_OFF;
   assign widx      = addr[AW+1:2];
   assign word      = ram[widx];
   assign store     = bus.MemWrite && known && !mis;
   assign push      = store && is_word && at_tx;
   assign pop       = bus.dbg_valid && bus.dbg_ready;
   assign mmio_rd   = !is_word ? '0 : at_status ? {30'b0, overflow, full} : at_cycle ? cycle : '0;
   assign bus.ReadData   = (!known || mis) ? '0 : in_ram ? load_lane(word, addr[1:0], f3) : mmio_rd;
   assign bus.misaligned = mis;
   assign bus.dbg_valid  = !empty;
   // Narrow stores replicate their data across lanes; the byte enables pick the live ones.
   assign be    = is_word ? 4'hF : is_half ? (addr[1] ? 4'hC : 4'h3) : 4'b0001 << addr[1:0];
   assign wdata = is_word ? bus.WriteData : is_half ? {2{bus.WriteData[15:0]}} : {4{bus.WriteData[7:0]}};
   always_ff @(posedge clk)
      if (store && in_ram)
         for (int i = 0; i < 4; i++)
            if (be[i]) ram[widx][8*i +: 8] <= wdata[8*i +: 8];
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         cycle    <= '0;
         overflow <= 1'b0;
      end else begin
         cycle <= cycle + 32'd1;
         if (store && is_word && at_status) overflow <= 1'b0;
         else if (push && full && !pop) overflow <= 1'b1;
      end
   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (bus.WriteData[7:0]),
      .dout  (bus.dbg_data),
      .full  (full),
      .empty (empty)
   );
endmodule
